imem_loader: RTL and testbench

Boot loader that writes the instruction memory the processor fetches from, via a byte stream from a UART receiver. It sits beside the processor in the top level: it accepts a framed program image, writes 32-bit words into instruction memory on its 12-bit address port, and holds the processor in reset while loading. Between loads it is idle and the processor runs normally.

---
 rtl/imem_loader_if.sv | 25 ++
 rtl/imem_loader.sv | 171 +++++++++++++++++
 tb/tb_imem_loader.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Signal bundle between imem_loader (master) and the UART byte source,
// instruction memory write port and top-level status/reset logic (slave).
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  imem_wEn;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_dataIn;
    logic                  cpu_reset;
    logic                  busy;
    logic                  done;
    logic                  error;

    modport master (
        input  rx_valid, rx_data,
        output imem_wEn, imem_addr, imem_dataIn, cpu_reset, busy, done, error
    );

    modport slave (
        output rx_valid, rx_data,
        input  imem_wEn, imem_addr, imem_dataIn, cpu_reset, busy, done, error
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: parses a framed UART program image into instruction memory while holding
// the CPU in reset. Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader #(
    parameter int ADDR_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic          clock,
    input  logic          reset,
    imem_loader_if.master bus
);
    localparam int               IDX_W     = ADDR_WIDTH + 1;
    localparam int               TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [16:0]      MAX_WORDS = 17'(1) << ADDR_WIDTH;
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       SYNC_BYTE = 8'hA5;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {RUN, LEN_HI, LEN_LO, DATA, CHECK, ERR} state_e;
`else
    typedef enum logic [2:0] {RUN, LEN_HI, LEN_LO, DATA, ERR} state_e;
`endif

    state_e                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [1:0]            byte_q, byte_d;
    logic [23:0]           asm_q, asm_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic                  done_q, done_d;
    logic                  cpu_reset_q, busy_q, error_q;
    logic                  in_frame, frame_end;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            chk_q, chk_d;
`endif

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        byte_d    = byte_q;
        asm_d     = asm_q;
        tmo_d     = tmo_q;
        wen_d     = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        done_d    = 1'b0;
        frame_end = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        chk_d     = chk_q;
`endif
        in_frame  = (state_q != RUN) && (state_q != ERR);

        if (in_frame) begin
            if (bus.rx_valid)           tmo_d   = '0;
            else if (tmo_q == TMO_LAST) state_d = ERR;
            else                        tmo_d   = tmo_q + 1'b1;
        end

        if (bus.rx_valid) begin
            unique case (state_q)
                RUN, ERR: begin
                    // Only a sync byte starts a frame; anything else is line noise.
                    if (bus.rx_data == SYNC_BYTE) begin
                        state_d = LEN_HI;
                        idx_d   = '0;
                        byte_d  = '0;
                        tmo_d   = '0;
`ifdef LOADER_CHECKSUM_EN
                        chk_d   = '0;
`endif
                    end
                end
                LEN_HI: begin
                    len_d[15:8] = bus.rx_data;
                    state_d     = LEN_LO;
                end
                LEN_LO: begin
                    len_d[7:0] = bus.rx_data;
                    if (len_d == 16'd0)                 frame_end = 1'b1;
                    else if ({1'b0, len_d} > MAX_WORDS) state_d   = ERR;
                    else                                state_d   = DATA;
                end
                DATA: begin
                    asm_d  = {asm_q[15:0], bus.rx_data};
                    byte_d = byte_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    chk_d  = chk_q ^ bus.rx_data;
`endif
                    if (byte_q == 2'd3) begin
                        wen_d     = 1'b1;
                        addr_d    = idx_q[ADDR_WIDTH-1:0];
                        data_d    = {asm_q, bus.rx_data};
                        idx_d     = idx_q + 1'b1;
                        frame_end = (32'(idx_q) + 32'd1 == 32'(len_q));
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHECK: begin
                    if (bus.rx_data == chk_q) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ERR;
                    end
                end
`endif
                default: ;
            endcase
        end

        if (frame_end) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = RUN;
            done_d  = 1'b1;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            len_q       <= '0;
            idx_q       <= '0;
            byte_q      <= '0;
            asm_q       <= '0;
            tmo_q       <= '0;
            wen_q       <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            done_q      <= 1'b0;
            cpu_reset_q <= 1'b0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            byte_q      <= byte_d;
            asm_q       <= asm_d;
            tmo_q       <= tmo_d;
            wen_q       <= wen_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            done_q      <= done_d;
            cpu_reset_q <= (state_d != RUN);
            busy_q      <= (state_d != RUN) && (state_d != ERR);
            error_q     <= (state_d == ERR);
`ifdef LOADER_CHECKSUM_EN
            chk_q       <= chk_d;
`endif
        end
    end

    assign bus.imem_wEn    = wen_q;
    assign bus.imem_addr   = addr_q;
    assign bus.imem_dataIn = data_q;
    assign bus.cpu_reset   = cpu_reset_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.error       = error_q;
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and randomized frames; the expected memory image is
// a plain list of words written at addresses 0..N-1.
module tb_imem_loader;
    localparam int AW  = 12;
    localparam int TMO = 50;
    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;
    logic [AW+31:0] wq[$];
    logic [31:0]    words[$];

    imem_loader_if #(.ADDR_WIDTH(AW)) bus ();
    imem_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Write and done observer, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.imem_wEn === 1'b1) wq.push_back({bus.imem_addr, bus.imem_dataIn});
        if (bus.done === 1'b1) done_cnt++;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bq_t make_frame();
        bq_t         fr;
        logic [7:0]  x = 8'h00;
        logic [15:0] n = 16'(words.size());
        fr.push_back(8'hA5);
        fr.push_back(n[15:8]);
        fr.push_back(n[7:0]);
        foreach (words[i]) begin
            for (int b = 3; b >= 0; b--) begin
                fr.push_back(words[i][8*b +: 8]);
                x ^= words[i][8*b +: 8];
            end
        end
`ifdef LOADER_CHECKSUM_EN
        fr.push_back(x);
`endif
        return fr;
    endfunction

    // Returns at the negedge of the cycle after the final byte.
    task automatic send_frame(input bq_t fr, input int max_gap, input bit expect_hold);
        int lapses = 0;
        int gap;
        for (int i = 0; i < fr.size(); i++) begin
            @(negedge clk);
            if (i > 0 && (bus.cpu_reset !== 1'b1 || bus.busy !== 1'b1)) lapses++;
            bus.rx_valid = 1'b1;
            bus.rx_data  = fr[i];
            if (i < fr.size() - 1) begin
                gap = $urandom_range(max_gap, 0);
                repeat (gap) begin
                    @(negedge clk);
                    if (bus.cpu_reset !== 1'b1 || bus.busy !== 1'b1) lapses++;
                    bus.rx_valid = 1'b0;
                end
            end
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
        if (expect_hold) check("cpu_reset/busy held mid-frame (lapses)", 64'(lapses), 0);
    endtask

    task automatic check_complete(input string tag);
        check({tag, " done"},      bus.done,      1);
        check({tag, " cpu_reset"}, bus.cpu_reset, 0);
        check({tag, " busy"},      bus.busy,      0);
        check({tag, " error"},     bus.error,     0);
        @(negedge clk);
        check({tag, " done one-shot"}, bus.done, 0);
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic compare_writes(input string tag);
        int f0 = fails;
        check({tag, " write count"}, 64'(wq.size()), 64'(words.size()));
        foreach (words[i]) begin
            if (i >= wq.size() || fails != f0) break;
            check({tag, " write addr/data"}, 64'(wq[i]), 64'({i[AW-1:0], words[i]}));
        end
        wq.delete();
    endtask

    initial begin
        bq_t fr;
        int  d0;
        int  n;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        repeat (3) @(negedge clk);
        check("reset imem_wEn",    bus.imem_wEn,    0);
        check("reset imem_addr",   bus.imem_addr,   0);
        check("reset imem_dataIn", bus.imem_dataIn, 0);
        check("reset cpu_reset",   bus.cpu_reset,   0);
        check("reset busy",        bus.busy,        0);
        check("reset done",        bus.done,        0);
        check("reset error",       bus.error,       0);
        rst = 1'b0;
        settle();

        // Two-word directed frame.
        words = '{32'h0000_0001, 32'h1234_5678};
        d0 = done_cnt;
        send_frame(make_frame(), 0, 1);
        check_complete("two-word");
        settle();
        check("two-word done count", 64'(done_cnt - d0), 1);
        compare_writes("two-word");

        // Empty image.
        words.delete();
        d0 = done_cnt;
        send_frame(make_frame(), 0, 1);
        check_complete("empty");
        settle();
        check("empty done count", 64'(done_cnt - d0), 1);
        compare_writes("empty");

        // Randomized images, alternating back-to-back and gapped bytes.
        for (int t = 0; t < 5; t++) begin
            n = $urandom_range(7, 1);
            words.delete();
            for (int k = 0; k < n; k++) words.push_back($urandom);
            if (t == 0) words[0] = 32'hA5A5_A5A5;
            d0 = done_cnt;
            send_frame(make_frame(), (t % 2 == 1) ? 3 : 0, 1);
            check_complete("random");
            settle();
            check("random done count", 64'(done_cnt - d0), 1);
            compare_writes("random");
        end

`ifdef LOADER_CHECKSUM_EN
        // Corrupted checksum: words land, then ERR.
        words = '{32'h0000_0001, 32'h1234_5678};
        fr = make_frame();
        fr[fr.size() - 1] = ~fr[fr.size() - 1];
        d0 = done_cnt;
        send_frame(fr, 0, 1);
        check("bad checksum error",     bus.error,     1);
        check("bad checksum cpu_reset", bus.cpu_reset, 1);
        check("bad checksum busy",      bus.busy,      0);
        settle();
        check("bad checksum done count", 64'(done_cnt - d0), 0);
        compare_writes("bad checksum");
`endif

        // Silence mid-frame: timeout into ERR with no write.
        words.delete();
        send_frame('{8'hA5, 8'h00, 8'h01, 8'h00, 8'h11}, 0, 1);
        repeat (TMO - 5) @(negedge clk);
        check("timeout not yet", bus.error, 0);
        repeat (10) @(negedge clk);
        check("timeout error",     bus.error,     1);
        check("timeout busy",      bus.busy,      0);
        check("timeout cpu_reset", bus.cpu_reset, 1);
        settle();
        compare_writes("timeout");

        // Valid frame from ERR clears the error.
        words = '{$urandom, $urandom, $urandom};
        d0 = done_cnt;
        send_frame(make_frame(), 1, 1);
        check_complete("recover");
        settle();
        check("recover done count", 64'(done_cnt - d0), 1);
        compare_writes("recover");

        // N = 2^AW + 1 is rejected right after the length bytes.
        words.delete();
        send_frame('{8'hA5, 8'h10, 8'h01}, 0, 1);
        check("oversize error",     bus.error,     1);
        check("oversize busy",      bus.busy,      0);
        check("oversize cpu_reset", bus.cpu_reset, 1);
        send_frame(make_frame(), 0, 1);
        check_complete("empty after oversize");
        settle();
        wq.delete();

        // Noise in RUN is ignored.
        d0 = done_cnt;
        send_frame('{8'h55, 8'h00}, 0, 0);
        check("noise cpu_reset", bus.cpu_reset, 0);
        check("noise busy",      bus.busy,      0);
        settle();
        check("noise done count", 64'(done_cnt - d0), 0);
        compare_writes("noise");

        // Largest legal image fills every address.
        words.delete();
        for (int k = 0; k < (1 << AW); k++) words.push_back($urandom);
        send_frame(make_frame(), 0, 1);
        check_complete("full image");
        settle();
        compare_writes("full image");

        // Reset two data bytes into a frame.
        words.delete();
        send_frame('{8'hA5, 8'h00, 8'h02, 8'hDE, 8'hAD}, 0, 1);
        rst = 1'b1;
        #1;
        check("midreset imem_wEn",    bus.imem_wEn,    0);
        check("midreset imem_addr",   bus.imem_addr,   0);
        check("midreset imem_dataIn", bus.imem_dataIn, 0);
        check("midreset cpu_reset",   bus.cpu_reset,   0);
        check("midreset busy",        bus.busy,        0);
        check("midreset error",       bus.error,       0);
        settle();
        rst = 1'b0;
        settle();
        compare_writes("midreset");
        words = '{$urandom, $urandom};
        send_frame(make_frame(), 2, 1);
        check_complete("after reset");
        settle();
        compare_writes("after reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
